// File: rtl/wb_sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM controller write FIFO.
package wb_sdram_ctrl_pkg;

  localparam int unsigned WR_FIFO_DEPTH = 4;
  localparam int unsigned WR_ENTRY_W    = 36;

  // Which 16-bit half of the current word is presented next on DQ
  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } half_e;

  // One stored write: byte selects plus data
  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_entry_t;

endpackage

// File: rtl/wb_sdram_ctrl_wr_fifo_if.sv
// Wishbone write side and SDRAM pop side of the write FIFO.
interface wb_sdram_ctrl_wr_fifo_if;

  logic        clear;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        rd_i;
  logic [15:0] q_o;
  logic [1:0]  dqm_o;
  logic        empty_o;

  modport slave (
    input  clear, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, rd_i,
    output wb_ack_o, q_o, dqm_o, empty_o
  );

  modport master (
    output clear, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, rd_i,
    input  wb_ack_o, q_o, dqm_o, empty_o
  );

endinterface

// File: rtl/wb_sdram_ctrl_wr_fifo_mem.sv
// Write FIFO storage: DEPTH x 36, synchronous write, asynchronous read, no reset.
module wb_sdram_ctrl_wr_fifo_mem
  import wb_sdram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WR_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WR_ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [WR_ENTRY_W-1:0] rdata
);

  logic [WR_ENTRY_W-1:0] mem [DEPTH];

  // Store the accepted word at the write pointer
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_sdram_ctrl_wr_fifo.sv
// Write FIFO from Wishbone slave port to SDRAM data path.
// Each 32-bit word is replayed as two 16-bit halves, high half first.
// Optional macro WB_SDRAM_CTRL_WR_FIFO_LEVEL_EN exposes the entry count on level_o.
module wb_sdram_ctrl_wr_fifo
  import wb_sdram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WR_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst,
  wb_sdram_ctrl_wr_fifo_if.slave     bus
`ifdef WB_SDRAM_CTRL_WR_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  half_e         h;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop_half;
  logic          pop_word;
  wr_entry_t     wr_entry;
  wr_entry_t     rd_entry;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i & ~full & ~bus.clear;
  assign pop_half = bus.rd_i & ~empty;
  assign pop_word = pop_half & (h == HALF_LO);
  assign wr_entry = '{sel: bus.wb_sel_i, dat: bus.wb_dat_i};

  wb_sdram_ctrl_wr_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer, count and half-select bookkeeping; clear outranks push and pop
  always_ff @(posedge clk_i) begin
    if (rst || bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      h      <= HALF_HI;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_half) begin
        h <= (h == HALF_HI) ? HALF_LO : HALF_HI;
      end
      if (pop_word) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop_word})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Present the selected half of the head entry and its byte mask
  always_comb begin
    bus.q_o   = rd_entry.dat[31:16];
    bus.dqm_o = 2'b11;
    if (h == HALF_LO) begin
      bus.q_o = rd_entry.dat[15:0];
    end
    if (!empty) begin
      bus.dqm_o = (h == HALF_HI) ? ~rd_entry.sel[3:2] : ~rd_entry.sel[1:0];
    end
  end

  assign bus.wb_ack_o = push;
  assign bus.empty_o  = empty;

`ifdef WB_SDRAM_CTRL_WR_FIFO_LEVEL_EN
  assign level_o = count;
`endif

endmodule
